reg_writeback_queue: RTL

//   Write-side driver for the 32x32 register file: accepts result writes (addr, data)

---
 rtl/reg_writeback_queue_if.sv | 48 ++++
 rtl/reg_writeback_queue.sv | 121 ++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue_if.sv
// Bundles the writeback request, regfile write port and hazard-check signals
// of reg_writeback_queue.
// Optional macro REG_WB_FORWARD_EN adds the forwarding data outputs.
interface reg_writeback_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          iValid;
  logic          oReady;
  logic [AW-1:0] iAddr;
  logic [DW-1:0] iData;
  logic          iHold;
  logic          oWrite;
  logic [AW-1:0] oAddrC;
  logic [DW-1:0] oRegC;
  logic [AW-1:0] iChkAddrA;
  logic [AW-1:0] iChkAddrB;
  logic          oHazardA;
  logic          oHazardB;
  logic [CW-1:0] oCount;
`ifdef REG_WB_FORWARD_EN
  logic [DW-1:0] oFwdA;
  logic [DW-1:0] oFwdB;
  logic          oFwdValidA;
  logic          oFwdValidB;
`endif

  // Producer / decode / regfile side
  modport master (
    output iValid, iAddr, iData, iHold, iChkAddrA, iChkAddrB,
    input  oReady, oWrite, oAddrC, oRegC, oHazardA, oHazardB, oCount
`ifdef REG_WB_FORWARD_EN
    , input oFwdA, oFwdB, oFwdValidA, oFwdValidB
`endif
  );

  // Queue side
  modport slave (
    input  iValid, iAddr, iData, iHold, iChkAddrA, iChkAddrB,
    output oReady, oWrite, oAddrC, oRegC, oHazardA, oHazardB, oCount
`ifdef REG_WB_FORWARD_EN
    , output oFwdA, oFwdB, oFwdValidA, oFwdValidB
`endif
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// Writeback queue in front of the 32x32 register file: buffers (addr, data)
// results, drains one per cycle onto the regfile write port and reports which
// registers still have a write pending so decode can detect RAW hazards.
// Optional macro REG_WB_FORWARD_EN adds youngest-match forwarding outputs.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic                 iClk,
  input logic                 nRst,
  reg_writeback_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] ent_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic empty;
  logic full;
  logic ready;
  logic write;
  logic push;
  logic pop;
  logic haz_a;
  logic haz_b;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Ready looks only at stored state, so a pop never frees a slot for a push
  // in the same cycle; both outputs are forced low while reset is asserted.
  assign ready = nRst && !full;
  assign write = nRst && !empty && !bus.iHold;

  // Writes to r0 are consumed by the handshake but never stored.
  assign push = bus.iValid && ready && (bus.iAddr != '0);
  assign pop  = write;

  assign bus.oReady   = ready;
  assign bus.oWrite   = write;
  assign bus.oAddrC   = empty ? '0 : ent_addr[rd_ptr];
  assign bus.oRegC    = empty ? '0 : ent_data[rd_ptr];
  assign bus.oHazardA = haz_a;
  assign bus.oHazardB = haz_b;
  assign bus.oCount   = count;

  // Pointers, occupancy and entry valid bits; pointers wrap modulo DEPTH.
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (pop) begin
        rd_ptr          <= rd_ptr + PW'(1);
        ent_vld[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr          <= wr_ptr + PW'(1);
        ent_vld[wr_ptr] <= 1'b1;
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // Entry payload storage; only meaningful where the matching valid bit is set.
  always_ff @(posedge iClk) begin
    if (push) begin
      ent_addr[wr_ptr] <= bus.iAddr;
      ent_data[wr_ptr] <= bus.iData;
    end
  end

  // Pending-write match against every stored entry, head included.
  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr[i] == bus.iChkAddrA)) haz_a = 1'b1;
      if (ent_vld[i] && (ent_addr[i] == bus.iChkAddrB)) haz_b = 1'b1;
    end
    if (bus.iChkAddrA == '0) haz_a = 1'b0;
    if (bus.iChkAddrB == '0) haz_b = 1'b0;
  end

`ifdef REG_WB_FORWARD_EN
  logic [DW-1:0] fwd_a;
  logic [DW-1:0] fwd_b;

  // Walk entries oldest to youngest so the last match wins.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_vld[rd_ptr + PW'(k)] && (ent_addr[rd_ptr + PW'(k)] == bus.iChkAddrA))
        fwd_a = ent_data[rd_ptr + PW'(k)];
      if (ent_vld[rd_ptr + PW'(k)] && (ent_addr[rd_ptr + PW'(k)] == bus.iChkAddrB))
        fwd_b = ent_data[rd_ptr + PW'(k)];
    end
    if (bus.iChkAddrA == '0) fwd_a = '0;
    if (bus.iChkAddrB == '0) fwd_b = '0;
  end

  assign bus.oFwdA      = fwd_a;
  assign bus.oFwdB      = fwd_b;
  assign bus.oFwdValidA = haz_a;
  assign bus.oFwdValidB = haz_b;
`endif

endmodule
